mem_sys: RTL
============

# mem_sys

Parametrised single-clock memory subsystem for the hmc-6502 test harness. It is the successor to the fixed two-phase memory model and sits on the CPU bus beside `chip`. It provides:
- a RAM region;
- a request/ready handshake with programmable wait states;
- a memory-mapped output port backed by a small FIFO that the testbench drains to observe program output.

## Interface
Parameters:
- ADDR_W, 16, bus address width
- DATA_W, 8, bus data width
- RAM_AW, 12, RAM occupies addresses 0 .. 2^RAM_AW-1
- PORT_ADDR, 16'hF000, address of output port / FIFO status register
- WAIT_STATES, 2, extra cycles inserted per access (0..15)
- FIFO_DEPTH, 4, output FIFO entries, power of two, ≥2

Ports:
- ph1  in  1  single clock, rising-edge
- reset  in  1  asynchronous, active-low reset
- address  in  ADDR_W  access address
- wdata  in  DATA_W  write data
- read_en  in  1  1 = read, 0 = write
- req  in  1  access request
- ready  out  1  access complete, one-cycle pulse
- rdata  out  DATA_W  read data, registered, held until next read completes
- port_data  out  DATA_W  FIFO head
- port_valid  out  1  FIFO non-empty
- port_pop  in  1  pop FIFO head
- port_full  out  1  FIFO full
- port_overflow  out  1  sticky: a port write was dropped

## Operation
- FSM has two states, IDLE and BUSY.
- **IDLE**: if req=1, capture address, wdata and read_en; load wait counter with WAIT_STATES; go to BUSY. Otherwise stay.
- **BUSY, counter ≠ 0**: decrement the counter.
- **BUSY, counter = 0**: perform the access, pulse ready, return to IDLE.
- req is ignored in BUSY. The requester keeps req high until ready. req=1 on the cycle ready is high does not start a new access; the next access is accepted on the following edge.
- Decode uses the captured address, in priority order:
  - address = PORT_ADDR: write pushes wdata into the FIFO; read returns {port_overflow, port_full, occupancy} packed LSB-first, zero-extended.
  - address < 2^RAM_AW: read or write RAM.
  - otherwise: reads return all ones; writes are discarded.
- FIFO push when full: data is dropped and port_overflow is set. port_overflow clears only on reset.
- Push and pop on the same edge: the pop is applied first, so a push to a full FIFO with port_pop=1 succeeds and does not set overflow.
- Pop when empty is ignored. Pointers wrap modulo FIFO_DEPTH. Occupancy is a separate counter, 0..FIFO_DEPTH.
- port_data and port_valid reflect the FIFO head combinationally from registered state.

## Timing
- Reset (asynchronous assert, synchronous release) forces:
  - state IDLE;
  - ready=0, rdata=0;
  - FIFO empty: port_valid=0, port_full=0, port_data=0;
  - port_overflow=0.
- RAM contents are not cleared by reset.
- Reset mid-access aborts the access. No RAM write or FIFO push occurs unless the completing edge preceded the reset assertion.
- Latency: access accepted at edge E; RAM write, FIFO push, rdata update and ready rise all happen at edge E+WAIT_STATES+1. ready is high for exactly one cycle.
- Back-to-back accesses with req held high: one access completes every WAIT_STATES+2 cycles.
- A FIFO push is visible on port_valid the cycle after its completing edge.

## Configuration
- **MEM_WAIT_EN defined**: the wait counter is instantiated and WAIT_STATES applies as above.
- **MEM_WAIT_EN undefined**: the counter is removed and WAIT_STATES is ignored. Every access behaves as WAIT_STATES=0: ready rises at E+1, and back-to-back throughput is one access per 2 cycles.

## Test plan
- **Reset values**: reset low mid-access with WAIT_STATES=2 → ready, rdata, port_valid, port_overflow all 0; no RAM write occurs.
- **RAM write/read latency**: write 8'hA5 to 16'h0123, then read 16'h0123 → rdata=8'hA5; each ready rises exactly 3 edges after acceptance. With MEM_WAIT_EN undefined → 1 edge.
- **Unmapped access**: read 16'h8000 with RAM_AW=12 → rdata=8'hFF. A write to 16'h8000 leaves RAM[0] unchanged.
- **FIFO fill and overflow**: 5 writes 8'h01..8'h05 to PORT_ADDR, FIFO_DEPTH=4, no pops → port_full=1, port_overflow=1. Pops return 01,02,03,04, then port_valid=0. A status read afterward returns 8'h80.
- **Push and pop when full**: FIFO full, a port write completing on the same edge as port_pop=1 → occupancy stays 4, port_overflow stays 0, and the new byte is last out.
- **Back-to-back requests**: req held high for 3 reads → exactly 3 ready pulses, spaced WAIT_STATES+2 cycles apart.

Source files
------------

// File: rtl/mem_sys.sv
// rtl/mem_sys.sv - memory subsystem: RAM, wait-state handshake, output port FIFO (optional MEM_WAIT_EN)
module mem_sys #(
  parameter int                ADDR_W      = 16,
  parameter int                DATA_W      = 8,
  parameter int                RAM_AW      = 12,
  parameter logic [ADDR_W-1:0] PORT_ADDR   = 16'hF000,
  parameter int                WAIT_STATES = 2,
  parameter int                FIFO_DEPTH  = 4
) (
  input  logic              ph1,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] wdata,
  input  logic              read_en,
  input  logic              req,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] port_data,
  output logic              port_valid,
  input  logic              port_pop,
  output logic              port_full,
  output logic              port_overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rd_q, rd_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              wait_done;

  logic [DATA_W-1:0] ram      [2**RAM_AW];
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              ovf_q, ovf_d;

  logic              fin, hit_port, hit_ram, ram_we, push, pop, full, push_ok;
  logic [DATA_W-1:0] status;

`ifdef MEM_WAIT_EN
  logic [3:0] cnt_q, cnt_d;

  // Wait counter: loaded on acceptance, counts down to zero while busy
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE && req)
      cnt_d = 4'(WAIT_STATES);
    else if (state_q == BUSY && cnt_q != 4'd0)
      cnt_d = cnt_q - 4'd1;
  end

  // Wait counter register
  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) cnt_q <= 4'd0;
    else        cnt_q <= cnt_d;
  end

  assign wait_done = (cnt_q == 4'd0);
`else
  assign wait_done = 1'b1;
`endif

  // Decode works on the captured address so the bus may change while busy
  assign fin      = (state_q == BUSY) && wait_done;
  assign hit_port = (addr_q == PORT_ADDR);
  assign hit_ram  = !hit_port && ((addr_q >> RAM_AW) == '0);
  assign ram_we   = fin && !rd_q && hit_ram;
  assign push     = fin && !rd_q && hit_port;
  assign pop      = port_pop && (occ_q != '0);
  assign full     = (occ_q == OCC_W'(FIFO_DEPTH));
  // A same-edge pop frees a slot before the push lands
  assign push_ok  = push && (!full || pop);
  assign status   = {ovf_q, full, (DATA_W-2)'(occ_q)};

  // Access FSM: next state, captured request, completion pulse and read data
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    ready_d = 1'b0;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = BUSY;
          addr_d  = address;
          wdata_d = wdata;
          rd_d    = read_en;
        end
      end
      BUSY: begin
        if (wait_done) begin
          state_d = IDLE;
          ready_d = 1'b1;
          if (rd_q) begin
            if (hit_port)     rdata_d = status;
            else if (hit_ram) rdata_d = ram[addr_q[RAM_AW-1:0]];
            else              rdata_d = '1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO pointer, occupancy and sticky overflow next state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (pop)             rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_ok)         wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (push && !push_ok) ovf_d   = 1'b1;
    occ_d = occ_q + OCC_W'(push_ok) - OCC_W'(pop);
  end

  // Control and FIFO bookkeeping registers
  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= 1'b0;
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage arrays are not cleared by reset; writes are suppressed while it is held
  always_ff @(posedge ph1) begin
    if (reset && ram_we)  ram[addr_q[RAM_AW-1:0]] <= wdata_q;
    if (reset && push_ok) fifo_mem[wr_ptr_q]      <= wdata_q;
  end

  assign ready         = ready_q;
  assign rdata         = rdata_q;
  assign port_valid    = (occ_q != '0);
  assign port_data     = port_valid ? fifo_mem[rd_ptr_q] : '0;
  assign port_full     = full;
  assign port_overflow = ovf_q;

endmodule
